// File: rtl/ex_mem_ctrl_pipe.sv
// EX-stage control resolution and EX->MEM control pipeline register.
// Decodes the RV32I branch condition and drives the zero-latency PCSrcE redirect.
// Registers RegWrite/MemWrite/ResultSrc into MEM. Hold and bubble insertion are supported.
// Counts taken redirects in a counter that either saturates or wraps.
module ex_mem_ctrl_pipe #(
  parameter int unsigned RS_W   = 2,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned SAT    = 1,
  parameter int unsigned BR_EXT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ValidE,
  input  logic             RegWriteE,
  input  logic             MemWriteE,
  input  logic [RS_W-1:0]  ResultSrcE,
  input  logic             JumpE,
  input  logic             BranchE,
  input  logic [2:0]       BranchTypeE,
  input  logic             ZeroE,
  input  logic             LtE,
  input  logic             LtuE,
  input  logic             StallM,
  input  logic             FlushM,
  output logic             PCSrcE,
  output logic             ValidM,
  output logic             RegWriteM,
  output logic             MemWriteM,
  output logic [RS_W-1:0]  ResultSrcM,
  output logic [CNT_W-1:0] RedirCnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             w_base;
  logic             w_cond;
  logic             w_pcsrc;
  logic             r_valid_m;
  logic             r_regwrite_m;
  logic             r_memwrite_m;
  logic [RS_W-1:0]  r_resultsrc_m;
  logic [CNT_W-1:0] r_cnt;

  // Branch condition: funct3[2:1] picks the comparison, funct3[0] inverts it.
  // Codes 010/011 are not RV32I branches and never resolve taken.
  always_comb begin
    w_base = ZeroE;
    w_cond = ZeroE;
    if (BR_EXT != 0) begin
      if (BranchTypeE[2]) begin
        w_base = BranchTypeE[1] ? LtuE : LtE;
      end else begin
        w_base = ZeroE;
      end
      if (BranchTypeE[2:1] == 2'b01) begin
        w_cond = 1'b0;
      end else begin
        w_cond = w_base ^ BranchTypeE[0];
      end
    end
  end

  // A stalled EX slot must not redirect; the redirect fires when the stall releases.
  assign w_pcsrc = ValidE & ~StallM & (JumpE | (BranchE & w_cond));
  assign PCSrcE  = w_pcsrc;

  // EX/MEM control register: bubble beats hold, and hold beats load.
  // Write enables are gated by ValidE so an invalid slot cannot write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid_m     <= 1'b0;
      r_regwrite_m  <= 1'b0;
      r_memwrite_m  <= 1'b0;
      r_resultsrc_m <= '0;
    end else if (FlushM) begin
      r_valid_m     <= 1'b0;
      r_regwrite_m  <= 1'b0;
      r_memwrite_m  <= 1'b0;
      r_resultsrc_m <= '0;
    end else if (!StallM) begin
      r_valid_m     <= ValidE;
      r_regwrite_m  <= RegWriteE & ValidE;
      r_memwrite_m  <= MemWriteE & ValidE;
      r_resultsrc_m <= ValidE ? ResultSrcE : '0;
    end
  end

  // Redirect counter. FlushM does not gate it, because the redirecting instruction is still valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_pcsrc) begin
      if ((SAT != 0) && (&r_cnt)) begin
        r_cnt <= r_cnt;
      end else begin
        r_cnt <= r_cnt + CNT_ONE;
      end
    end
  end

  assign ValidM     = r_valid_m;
  assign RegWriteM  = r_regwrite_m;
  assign MemWriteM  = r_memwrite_m;
  assign ResultSrcM = r_resultsrc_m;
  assign RedirCnt   = r_cnt;

endmodule

// File: tb/tb_ex_mem_ctrl_pipe.sv
// Randomized plus directed bench for ex_mem_ctrl_pipe.
// Instance a uses the default parameters.
// Instance b has a 4-bit saturating counter.
// Instance c has a 4-bit wrapping counter and uses legacy branch decode.
module tb_ex_mem_ctrl_pipe;

  logic clk = 1'b0;
  logic reset;
  logic ValidE, RegWriteE, MemWriteE, JumpE, BranchE, ZeroE, LtE, LtuE, StallM, FlushM;
  logic [1:0] ResultSrcE;
  logic [2:0] BranchTypeE;

  logic a_pc, a_vm, a_rw, a_mw;
  logic [1:0] a_rs;
  logic [15:0] a_cnt;
  logic b_pc, b_vm, b_rw, b_mw;
  logic [1:0] b_rs;
  logic [3:0] b_cnt;
  logic c_pc, c_vm, c_rw, c_mw;
  logic [1:0] c_rs;
  logic [3:0] c_cnt;

  int n_chk = 0;
  int n_err = 0;

  // reference state
  bit m_vm, m_rw, m_mw;
  bit [1:0] m_rs;
  int c16, c4s, c4w;

  always #5 clk = ~clk;

  ex_mem_ctrl_pipe #(.RS_W(2), .CNT_W(16), .SAT(1), .BR_EXT(1)) dut_a (
    .clk(clk), .reset(reset), .ValidE(ValidE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
    .ResultSrcE(ResultSrcE), .JumpE(JumpE), .BranchE(BranchE), .BranchTypeE(BranchTypeE),
    .ZeroE(ZeroE), .LtE(LtE), .LtuE(LtuE), .StallM(StallM), .FlushM(FlushM),
    .PCSrcE(a_pc), .ValidM(a_vm), .RegWriteM(a_rw), .MemWriteM(a_mw), .ResultSrcM(a_rs),
    .RedirCnt(a_cnt));

  ex_mem_ctrl_pipe #(.RS_W(2), .CNT_W(4), .SAT(1), .BR_EXT(1)) dut_b (
    .clk(clk), .reset(reset), .ValidE(ValidE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
    .ResultSrcE(ResultSrcE), .JumpE(JumpE), .BranchE(BranchE), .BranchTypeE(BranchTypeE),
    .ZeroE(ZeroE), .LtE(LtE), .LtuE(LtuE), .StallM(StallM), .FlushM(FlushM),
    .PCSrcE(b_pc), .ValidM(b_vm), .RegWriteM(b_rw), .MemWriteM(b_mw), .ResultSrcM(b_rs),
    .RedirCnt(b_cnt));

  ex_mem_ctrl_pipe #(.RS_W(2), .CNT_W(4), .SAT(0), .BR_EXT(0)) dut_c (
    .clk(clk), .reset(reset), .ValidE(ValidE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
    .ResultSrcE(ResultSrcE), .JumpE(JumpE), .BranchE(BranchE), .BranchTypeE(BranchTypeE),
    .ZeroE(ZeroE), .LtE(LtE), .LtuE(LtuE), .StallM(StallM), .FlushM(FlushM),
    .PCSrcE(c_pc), .ValidM(c_vm), .RegWriteM(c_rw), .MemWriteM(c_mw), .ResultSrcM(c_rs),
    .RedirCnt(c_cnt));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  function automatic bit ref_cond(bit ext);
    if (!ext) return ZeroE;
    case (BranchTypeE)
      3'b000:  return ZeroE;
      3'b001:  return !ZeroE;
      3'b100:  return LtE;
      3'b101:  return !LtE;
      3'b110:  return LtuE;
      3'b111:  return !LtuE;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit ref_pc(bit ext);
    return ValidE && !StallM && (JumpE || (BranchE && ref_cond(ext)));
  endfunction

  task automatic model_clear();
    m_vm = 0; m_rw = 0; m_mw = 0; m_rs = 0;
    c16 = 0; c4s = 0; c4w = 0;
  endtask

  task automatic check_regs(input string tag);
    chk({tag, "_vm_a"}, 32'(a_vm), 32'(m_vm));
    chk({tag, "_rw_a"}, 32'(a_rw), 32'(m_rw));
    chk({tag, "_mw_a"}, 32'(a_mw), 32'(m_mw));
    chk({tag, "_rs_a"}, 32'(a_rs), 32'(m_rs));
    chk({tag, "_vm_b"}, 32'(b_vm), 32'(m_vm));
    chk({tag, "_rs_b"}, 32'(b_rs), 32'(m_rs));
    chk({tag, "_vm_c"}, 32'(c_vm), 32'(m_vm));
    chk({tag, "_rw_c"}, 32'(c_rw), 32'(m_rw));
    chk({tag, "_mw_c"}, 32'(c_mw), 32'(m_mw));
    chk({tag, "_cnt_a"}, 32'(a_cnt), 32'(c16));
    chk({tag, "_cnt_b"}, 32'(b_cnt), 32'(c4s));
    chk({tag, "_cnt_c"}, 32'(c_cnt), 32'(c4w));
  endtask

  // One clock: check the combinational redirect, advance the model at the edge, check the registers.
  task automatic cyc(input string tag);
    bit pe, pl;
    pe = ref_pc(1'b1);
    pl = ref_pc(1'b0);
    #1;
    chk({tag, "_pc_a"}, 32'(a_pc), 32'(pe));
    chk({tag, "_pc_b"}, 32'(b_pc), 32'(pe));
    chk({tag, "_pc_c"}, 32'(c_pc), 32'(pl));
    @(posedge clk);
    if (FlushM) begin
      m_vm = 0; m_rw = 0; m_mw = 0; m_rs = 0;
    end else if (!StallM) begin
      m_vm = ValidE;
      m_rw = ValidE && RegWriteE;
      m_mw = ValidE && MemWriteE;
      m_rs = ValidE ? ResultSrcE : 2'd0;
    end
    if (pe) begin
      c16 = (c16 == 65535) ? c16 : c16 + 1;
      c4s = (c4s == 15) ? c4s : c4s + 1;
    end
    if (pl) c4w = (c4w + 1) % 16;
    #1;
    check_regs(tag);
    @(negedge clk);
  endtask

  task automatic idle();
    ValidE = 0; RegWriteE = 0; MemWriteE = 0; ResultSrcE = 0; JumpE = 0; BranchE = 0;
    BranchTypeE = 0; ZeroE = 0; LtE = 0; LtuE = 0; StallM = 0; FlushM = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    #1;
    model_clear();
    check_regs("rst");
    @(negedge clk);
    reset = 0;
  endtask

  int base;

  initial begin
    reset = 1;
    idle();
    @(negedge clk);
    do_reset();

    // Branch taken on funct3=101 with LtE=0, then funct3=010 never taken.
    ValidE = 1; BranchE = 1; BranchTypeE = 3'b101; LtE = 0;
    cyc("t2a");
    chk("t2_cnt1", 32'(a_cnt), 32'd1);
    BranchTypeE = 3'b010; ZeroE = 1; LtE = 1; LtuE = 1;
    #1 chk("t2_pc010", 32'(a_pc), 32'd0);
    cyc("t2b");
    chk("t2_cnt_hold", 32'(a_cnt), 32'd1);

    // Stall for 3 cycles with a jump pending, then release.
    idle(); ValidE = 1; RegWriteE = 1; ResultSrcE = 2'd1;
    cyc("t3load");
    ValidE = 1; JumpE = 1; RegWriteE = 0; MemWriteE = 1; ResultSrcE = 2'd2; StallM = 1;
    base = a_cnt;
    for (int i = 0; i < 3; i++) cyc("t3stall");
    chk("t3_held_rw", 32'(a_rw), 32'd1);
    chk("t3_held_mw", 32'(a_mw), 32'd0);
    chk("t3_cnt_stall", 32'(a_cnt), 32'(base));
    StallM = 0;
    cyc("t3rel");
    chk("t3_cnt_rel", 32'(a_cnt), 32'(base + 1));
    chk("t3_mw_rel", 32'(a_mw), 32'd1);

    // Flush and stall together produce a bubble.
    idle(); ValidE = 1; RegWriteE = 1; MemWriteE = 1; ResultSrcE = 2'd3;
    cyc("t4load");
    FlushM = 1; StallM = 1;
    cyc("t4flush");
    chk("t4_vm", 32'(a_vm), 32'd0);
    chk("t4_rs", 32'(a_rs), 32'd0);

    // An invalid slot is loaded as an empty control word.
    idle(); ValidE = 0; RegWriteE = 1; MemWriteE = 1; ResultSrcE = 2'd2; JumpE = 1;
    cyc("t5");
    chk("t5_rw", 32'(a_rw), 32'd0);
    chk("t5_rs", 32'(a_rs), 32'd0);

    // Reset asserted mid-stream clears state with no clock edge. PCSrcE stays combinational.
    idle(); ValidE = 1; RegWriteE = 1; MemWriteE = 1; ResultSrcE = 2'd3; JumpE = 1;
    cyc("t1load");
    reset = 1;
    #2;
    model_clear();
    check_regs("t1rst");
    chk("t1_pc_in_reset", 32'(a_pc), 32'd1);
    reset = 0;
    @(negedge clk);

    // Counter limits: 17 jumps from reset.
    idle();
    do_reset();
    ValidE = 1; JumpE = 1;
    for (int i = 0; i < 17; i++) cyc("t6jmp");
    chk("t6_sat", 32'(b_cnt), 32'd15);
    chk("t6_wrap", 32'(c_cnt), 32'd1);
    chk("t6_wide", 32'(a_cnt), 32'd17);
    JumpE = 0; BranchE = 1; BranchTypeE = 3'b001; ZeroE = 1;
    #1;
    chk("t6_legacy_taken", 32'(c_pc), 32'd1);
    chk("t6_ext_not_taken", 32'(a_pc), 32'd0);
    cyc("t6leg");

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      ValidE      = ($urandom_range(0, 9) < 8);
      RegWriteE   = $urandom_range(0, 1);
      MemWriteE   = $urandom_range(0, 1);
      ResultSrcE  = 2'($urandom_range(0, 3));
      JumpE       = ($urandom_range(0, 9) < 2);
      BranchE     = ($urandom_range(0, 9) < 4);
      BranchTypeE = 3'($urandom_range(0, 7));
      ZeroE       = $urandom_range(0, 1);
      LtE         = $urandom_range(0, 1);
      LtuE        = $urandom_range(0, 1);
      StallM      = ($urandom_range(0, 9) < 2);
      FlushM      = ($urandom_range(0, 9) < 1);
      cyc("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
